tl_a_arbiter: RTL and testbench

Round-robin arbiter that shares one TileLink-UL single-beat A/D port among NREQ requesters in the E31 eval subsystem. It sits directly upstream of the top-level passthrough port bundle. The A channel is registered, and a requester index is prepended to the source ID. D responses are routed back by decoding that index. A per-requester outstanding counter limits in-flight requests to MAX_OUT.

---
 rtl/tl_a_arbiter.sv | 175 +++++++++++++++++
 tb/tb_tl_a_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_a_arbiter.sv
// tl_a_arbiter: round-robin share of one TileLink-UL A/D port.
// A is registered with a requester index prepended to source; D routes back.
module tl_a_arbiter #(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SRC_W   = 2,
  parameter int MAX_OUT = 4,
  localparam int IDX_W  = (NREQ > 2) ? $clog2(NREQ) : 1,
  localparam int MASK_W = DATA_W / 8,
  localparam int OSRC_W = IDX_W + SRC_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_a_valid,
  output logic [NREQ-1:0]          req_a_ready,
  input  logic [NREQ*3-1:0]        req_a_opcode,
  input  logic [NREQ*ADDR_W-1:0]   req_a_address,
  input  logic [NREQ*DATA_W-1:0]   req_a_data,
  input  logic [NREQ*MASK_W-1:0]   req_a_mask,
  input  logic [NREQ*SRC_W-1:0]    req_a_source,
  output logic                     out_a_valid,
  input  logic                     out_a_ready,
  output logic [2:0]               out_a_opcode,
  output logic [ADDR_W-1:0]        out_a_address,
  output logic [DATA_W-1:0]        out_a_data,
  output logic [MASK_W-1:0]        out_a_mask,
  output logic [OSRC_W-1:0]        out_a_source,
  input  logic                     out_d_valid,
  output logic                     out_d_ready,
  input  logic [2:0]               out_d_opcode,
  input  logic [DATA_W-1:0]        out_d_data,
  input  logic                     out_d_error,
  input  logic [OSRC_W-1:0]        out_d_source,
  output logic [NREQ-1:0]          req_d_valid,
  input  logic [NREQ-1:0]          req_d_ready,
  output logic [2:0]               req_d_opcode,
  output logic [DATA_W-1:0]        req_d_data,
  output logic                     req_d_error,
  output logic [SRC_W-1:0]         req_d_source,
  output logic                     route_err
);

  localparam logic [IDX_W:0] NREQ_L  = (IDX_W+1)'(NREQ);
  localparam logic [3:0]     CNT_MAX = 4'(MAX_OUT);

  logic              slot_valid;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [MASK_W-1:0] mask_q;
  logic [OSRC_W-1:0] src_q;
  logic [IDX_W-1:0]  ptr;
  logic [3:0]        outst [NREQ];
  logic              err_q;

  logic              slot_free;
  logic              gnt_any;
  logic              a_fire;
  logic [IDX_W-1:0]  gnt;
  logic [IDX_W-1:0]  gnt_nxt;
  logic [NREQ-1:0]   elig;
  logic [NREQ-1:0]   inc_v;
  logic [NREQ-1:0]   dec_v;
  logic [IDX_W-1:0]  d_idx;
  logic              d_hit;
  logic              d_fire;

  assign slot_free = !slot_valid || out_a_ready;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++)
      elig[i] = req_a_valid[i] && (outst[i] < CNT_MAX);
  end

  // Scan downward so the candidate closest to ptr is assigned last.
  always_comb begin
    int j;
    j = 0;
    gnt_any = 1'b0;
    gnt = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (elig[j]) begin
        gnt_any = 1'b1;
        gnt = IDX_W'(j);
      end
    end
  end

  assign gnt_nxt = (gnt == IDX_W'(NREQ - 1)) ? '0 : gnt + 1'b1;
  assign a_fire  = reset && slot_free && gnt_any;

  always_comb begin
    req_a_ready = '0;
    if (a_fire) req_a_ready[gnt] = 1'b1;
  end

  assign d_idx = out_d_source[OSRC_W-1 -: IDX_W];
  assign d_hit = {1'b0, d_idx} < NREQ_L;

  always_comb begin
    req_d_valid = '0;
    out_d_ready = 1'b0;
    if (reset) begin
      if (d_hit) begin
        req_d_valid[d_idx] = out_d_valid;
        out_d_ready = req_d_ready[d_idx];
      end else begin
        out_d_ready = 1'b1;
      end
    end
  end

  assign d_fire = out_d_valid && out_d_ready && d_hit;

  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int i = 0; i < NREQ; i++) begin
      inc_v[i] = a_fire && (gnt == IDX_W'(i));
      dec_v[i] = d_fire && (d_idx == IDX_W'(i));
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      slot_valid <= 1'b0;
      op_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      mask_q <= '0;
      src_q <= '0;
      ptr <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < NREQ; i++) outst[i] <= '0;
    end else begin
      if (a_fire) begin
        slot_valid <= 1'b1;
        op_q <= req_a_opcode[int'(gnt)*3 +: 3];
        addr_q <= req_a_address[int'(gnt)*ADDR_W +: ADDR_W];
        data_q <= req_a_data[int'(gnt)*DATA_W +: DATA_W];
        mask_q <= req_a_mask[int'(gnt)*MASK_W +: MASK_W];
        src_q <= {gnt, req_a_source[int'(gnt)*SRC_W +: SRC_W]};
        ptr <= gnt_nxt;
      end else if (out_a_ready) begin
        slot_valid <= 1'b0;
      end
      if (out_d_valid && !d_hit) err_q <= 1'b1;
      // Counter saturates at zero on a stray response.
      for (int i = 0; i < NREQ; i++) begin
        if (inc_v[i] && !dec_v[i])
          outst[i] <= outst[i] + 4'd1;
        else if (dec_v[i] && !inc_v[i] && outst[i] != 4'd0)
          outst[i] <= outst[i] - 4'd1;
      end
    end
  end

  assign out_a_valid   = slot_valid;
  assign out_a_opcode  = op_q;
  assign out_a_address = addr_q;
  assign out_a_data    = data_q;
  assign out_a_mask    = mask_q;
  assign out_a_source  = src_q;
  assign route_err     = err_q;

  assign req_d_opcode = out_d_opcode;
  assign req_d_data   = out_d_data;
  assign req_d_error  = out_d_error;
  assign req_d_source = out_d_source[SRC_W-1:0];

endmodule

// File: tb/tb_tl_a_arbiter.sv
// tb_tl_a_arbiter: randomized scoreboard bench for tl_a_arbiter.
// Reference model tracks in-flight counts, pointer and expected A beats.
module tb_tl_a_arbiter;
  localparam int NREQ = 3;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SRC_W = 2;
  localparam int MAX_OUT = 4;
  localparam int IDX_W = 2;
  localparam int MASK_W = 4;
  localparam int SW = IDX_W + SRC_W;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [NREQ-1:0] req_a_valid = '0;
  logic [NREQ-1:0] req_a_ready;
  logic [NREQ*3-1:0] req_a_opcode = '0;
  logic [NREQ*ADDR_W-1:0] req_a_address = '0;
  logic [NREQ*DATA_W-1:0] req_a_data = '0;
  logic [NREQ*MASK_W-1:0] req_a_mask = '0;
  logic [NREQ*SRC_W-1:0] req_a_source = '0;
  logic out_a_valid;
  logic out_a_ready = 1'b0;
  logic [2:0] out_a_opcode;
  logic [ADDR_W-1:0] out_a_address;
  logic [DATA_W-1:0] out_a_data;
  logic [MASK_W-1:0] out_a_mask;
  logic [SW-1:0] out_a_source;
  logic out_d_valid = 1'b0;
  logic out_d_ready;
  logic [2:0] out_d_opcode = '0;
  logic [DATA_W-1:0] out_d_data = '0;
  logic out_d_error = 1'b0;
  logic [SW-1:0] out_d_source = '0;
  logic [NREQ-1:0] req_d_valid;
  logic [NREQ-1:0] req_d_ready = '0;
  logic [2:0] req_d_opcode;
  logic [DATA_W-1:0] req_d_data;
  logic req_d_error;
  logic [SRC_W-1:0] req_d_source;
  logic route_err;

  tl_a_arbiter #(
    .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .SRC_W(SRC_W), .MAX_OUT(MAX_OUT)
  ) dut (
    .clock(clock), .reset(reset),
    .req_a_valid(req_a_valid), .req_a_ready(req_a_ready),
    .req_a_opcode(req_a_opcode), .req_a_address(req_a_address),
    .req_a_data(req_a_data), .req_a_mask(req_a_mask),
    .req_a_source(req_a_source),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready),
    .out_a_opcode(out_a_opcode), .out_a_address(out_a_address),
    .out_a_data(out_a_data), .out_a_mask(out_a_mask),
    .out_a_source(out_a_source),
    .out_d_valid(out_d_valid), .out_d_ready(out_d_ready),
    .out_d_opcode(out_d_opcode), .out_d_data(out_d_data),
    .out_d_error(out_d_error), .out_d_source(out_d_source),
    .req_d_valid(req_d_valid), .req_d_ready(req_d_ready),
    .req_d_opcode(req_d_opcode), .req_d_data(req_d_data),
    .req_d_error(req_d_error), .req_d_source(req_d_source),
    .route_err(route_err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
    logic [SW-1:0] src;
  } beat_t;

  beat_t exp_q[$];
  int n_chk = 0;
  int n_pass = 0;
  int cnt [NREQ];
  int ptr_m = 0;
  bit busy_m = 0;
  bit err_m = 0;

  logic rst_k = 1'b0;
  logic [NREQ-1:0] vmask = '0;
  int a_pct = 0, rdy_pct = 0, d_pct = 0, drdy_pct = 0, bad_pct = 0;
  int force_src = -1;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic step();
    int g, idx, pick, j;
    logic [NREQ-1:0] exp_rdy, exp_dv;
    logic exp_odr;
    beat_t b;
    @(negedge clock);
    reset = rst_k;
    for (int i = 0; i < NREQ; i++) begin
      req_a_valid[i] = vmask[i] && ($urandom_range(0, 99) < a_pct);
      req_a_opcode[i*3 +: 3] = 3'($urandom);
      req_a_address[i*ADDR_W +: ADDR_W] = $urandom;
      req_a_data[i*DATA_W +: DATA_W] = $urandom;
      req_a_mask[i*MASK_W +: MASK_W] = 4'($urandom);
      req_a_source[i*SRC_W +: SRC_W] = 2'($urandom);
      req_d_ready[i] = $urandom_range(0, 99) < drdy_pct;
    end
    out_a_ready = $urandom_range(0, 99) < rdy_pct;
    out_d_opcode = 3'($urandom);
    out_d_data = $urandom;
    out_d_error = 1'($urandom);
    out_d_valid = 1'b0;
    out_d_source = SW'($urandom);
    if (force_src >= 0) begin
      out_d_valid = 1'b1;
      out_d_source = SW'(force_src);
    end else if ($urandom_range(0, 99) < bad_pct) begin
      out_d_valid = 1'b1;
      out_d_source = {2'd3, 2'($urandom)};
    end else if ($urandom_range(0, 99) < d_pct) begin
      pick = $urandom_range(0, NREQ - 1);
      idx = -1;
      for (int k = 0; k < NREQ; k++)
        if (idx < 0 && cnt[(pick + k) % NREQ] > 0) idx = (pick + k) % NREQ;
      if (idx < 0 && $urandom_range(0, 9) == 0) idx = pick;
      if (idx >= 0) begin
        out_d_valid = 1'b1;
        out_d_source = {2'(idx), 2'($urandom)};
      end
    end
    #2;
    chk("out_a_valid", out_a_valid, busy_m);
    chk("route_err", route_err, err_m);
    if (!reset) begin
      chk("a_ready_in_reset", req_a_ready, 0);
      chk("d_valid_in_reset", req_d_valid, 0);
      chk("d_ready_in_reset", out_d_ready, 0);
      for (int i = 0; i < NREQ; i++) cnt[i] = 0;
      ptr_m = 0;
      busy_m = 0;
      err_m = 0;
      exp_q.delete();
      return;
    end
    g = -1;
    if (!busy_m || out_a_ready)
      for (int k = 0; k < NREQ; k++) begin
        j = (ptr_m + k) % NREQ;
        if (g < 0 && req_a_valid[j] && cnt[j] < MAX_OUT) g = j;
      end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_a_ready", req_a_ready, exp_rdy);
    idx = int'(out_d_source[SW-1 -: IDX_W]);
    exp_dv = '0;
    if (idx < NREQ) begin
      exp_odr = req_d_ready[idx];
      if (out_d_valid) exp_dv[idx] = 1'b1;
    end else begin
      exp_odr = 1'b1;
    end
    chk("out_d_ready", out_d_ready, exp_odr);
    chk("req_d_valid", req_d_valid, exp_dv);
    chk("req_d_payload", {req_d_opcode, req_d_data, req_d_error, req_d_source},
        {out_d_opcode, out_d_data, out_d_error, out_d_source[SRC_W-1:0]});
    if (g >= 0) begin
      b.op = req_a_opcode[g*3 +: 3];
      b.addr = req_a_address[g*ADDR_W +: ADDR_W];
      b.data = req_a_data[g*DATA_W +: DATA_W];
      b.mask = req_a_mask[g*MASK_W +: MASK_W];
      b.src = {2'(g), req_a_source[g*SRC_W +: SRC_W]};
      exp_q.push_back(b);
      cnt[g]++;
      ptr_m = (g + 1) % NREQ;
    end
    if (out_d_valid && idx < NREQ && req_d_ready[idx] && cnt[idx] > 0)
      cnt[idx]--;
    if (out_d_valid && idx >= NREQ) err_m = 1;
    busy_m = (g >= 0) || (busy_m && !out_a_ready);
  endtask

  always @(negedge clock) begin
    #3;
    if (reset && out_a_valid) begin
      if (exp_q.size() == 0) begin
        chk("out_a_unexpected", 1, 0);
      end else begin
        chk("out_a_beat", {out_a_opcode, out_a_address, out_a_data,
                           out_a_mask, out_a_source}, exp_q[0]);
        if (out_a_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    for (int i = 0; i < NREQ; i++) cnt[i] = 0;
    rst_k = 1'b0;
    vmask = '1; a_pct = 100; rdy_pct = 100;
    repeat (3) step();
    chk("reset_payload", {out_a_opcode, out_a_address, out_a_data,
                          out_a_mask, out_a_source}, 0);

    rst_k = 1'b1;
    vmask = '0; a_pct = 0; rdy_pct = 0; d_pct = 0; drdy_pct = 0;
    repeat (2) step();
    out_d_source = '0;
    #1;
    chk("idle_d_ready", out_d_ready, 0);
    chk("idle_d_valid", req_d_valid, 0);

    vmask = 3'b011; a_pct = 100; rdy_pct = 100; d_pct = 100; drdy_pct = 100;
    repeat (20) step();

    vmask = '0;
    repeat (30) step();
    vmask = 3'b001; d_pct = 0;
    repeat (8) step();
    chk("sat_ready", req_a_ready, 0);
    force_src = 1;
    step();
    chk("ret_d_valid", req_d_valid, 3'b001);
    chk("ret_d_source", req_d_source, 2'd1);
    force_src = -1;
    step();
    chk("regrant", req_a_ready, 3'b001);

    vmask = '1; d_pct = 50; rdy_pct = 0;
    repeat (6) step();
    rdy_pct = 100;
    repeat (3) step();

    bad_pct = 100;
    step();
    bad_pct = 0;
    repeat (5) step();
    chk("err_sticky", route_err, 1);

    a_pct = 60; rdy_pct = 70; d_pct = 60; drdy_pct = 70;
    for (int n = 0; n < 3000; n++) begin
      rst_k = ($urandom_range(0, 199) != 0);
      bad_pct = ($urandom_range(0, 299) == 0) ? 100 : 0;
      step();
    end
    rst_k = 1'b1; bad_pct = 0;

    vmask = '1; a_pct = 100; rdy_pct = 0; d_pct = 0;
    repeat (2) step();
    chk("burst_held", out_a_valid, 1);
    rst_k = 1'b0;
    step();
    rst_k = 1'b1;
    step();
    chk("post_reset_grant", req_a_ready, 3'b001);

    vmask = '0; rdy_pct = 100;
    for (int n = 0; n < 50 && (exp_q.size() != 0 || busy_m); n++) step();
    step();
    chk("drain_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
